// File: rtl/coh_msg_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : coh_msg_sched_if
//  Description : Signal bundle between the coherence message scheduler and
//                its environment: per-cache request/message ports, the shared
//                broadcast bus, snoop acknowledges and completion reporting.
//  Revision    : 1.0
// ============================================================================
interface coh_msg_sched_if #(
    parameter int CACHE_NUM  = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int ID_W  = $clog2(CACHE_NUM);
    localparam int MSG_W = 4 + 2*ID_W + ADDR_WIDTH;

    logic [CACHE_NUM-1:0]       msg_req;
    logic [CACHE_NUM*MSG_W-1:0] msg;
    logic [CACHE_NUM-1:0]       msg_gnt;
    logic                       bus_valid;
    logic [MSG_W-1:0]           bus_msg;
    logic                       bus_ready;
    logic [CACHE_NUM-1:0]       snoop_ack;
    logic [CACHE_NUM-1:0]       msg_done;
    logic                       timeout_err;
    logic                       busy;

    // Scheduler side: owns the broadcast bus
    modport master (
        input  msg_req, msg, bus_ready, snoop_ack,
        output msg_gnt, bus_valid, bus_msg, msg_done, timeout_err, busy
    );

    // Environment side: caches and bus fabric
    modport slave (
        output msg_req, msg, bus_ready, snoop_ack,
        input  msg_gnt, bus_valid, bus_msg, msg_done, timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/coh_msg_sched.sv
`default_nettype none
// ============================================================================
//  Module      : coh_msg_sched
//  Description : Round-robin scheduler that serialises coherence messages
//                from CACHE_NUM caches onto one broadcast bus, collects snoop
//                acks from every non-source cache and reports completion or
//                ack timeout to the source.
//  Revision    : 1.0
// ============================================================================
module coh_msg_sched #(
    parameter int CACHE_NUM   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    coh_msg_sched_if.master     bus
);
    localparam int ID_W  = $clog2(CACHE_NUM);
    localparam int MSG_W = 4 + 2*ID_W + ADDR_WIDTH;
    // Timer only ever needs to reach ACK_TIMEOUT-1
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_src;
    logic [CACHE_NUM-1:0]   r_pending;
    logic [TMR_W-1:0]       r_timer;
    logic [MSG_W-1:0]       r_bus_msg;
    logic [CACHE_NUM-1:0]   r_msg_done;
    logic                   r_timeout_err;

    logic [MSG_W-1:0]       w_slot [CACHE_NUM];
    logic                   w_gnt_any;
    logic [ID_W-1:0]        w_gnt_idx;
    logic [ID_W:0]          w_scan_sum;
    logic [ID_W-1:0]        w_scan_idx;
    logic [CACHE_NUM-1:0]   w_pend_nxt;
    logic                   w_all_acked;
    logic                   w_tmo;
    logic [ID_W-1:0]        w_src_inc;

    // Split the flat message vector into per-cache slots
    for (genvar g = 0; g < CACHE_NUM; g++) begin : g_slot
        assign w_slot[g] = bus.msg[g*MSG_W +: MSG_W];
    end

    // Round-robin scan: first requester at or above rr_ptr, wrapping modulo CACHE_NUM
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        for (int k = 0; k < CACHE_NUM; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan_sum >= (ID_W+1)'(CACHE_NUM)) begin
                w_scan_sum = w_scan_sum - (ID_W+1)'(CACHE_NUM);
            end
            w_scan_idx = w_scan_sum[ID_W-1:0];
            if (!w_gnt_any && bus.msg_req[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    // Acks against the source bit are harmless: its pending bit is already clear
    assign w_pend_nxt  = r_pending & ~bus.snoop_ack;
    assign w_all_acked = (w_pend_nxt == '0);
    assign w_tmo       = (r_timer == TMR_W'(ACK_TIMEOUT - 1));
    assign w_src_inc   = (r_src == ID_W'(CACHE_NUM - 1)) ? '0 : r_src + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (w_gnt_any)               w_state_nxt = S_SEND;
            S_SEND:     if (bus.bus_ready)           w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (w_all_acked || w_tmo)    w_state_nxt = S_IDLE;
            default:                                 w_state_nxt = S_IDLE;
        endcase
    end

    // Message latch, ack bookkeeping, round-robin pointer and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_src         <= '0;
            r_pending     <= '0;
            r_timer       <= '0;
            r_bus_msg     <= '0;
            r_msg_done    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_msg_done    <= '0;
            r_timeout_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_bus_msg <= w_slot[w_gnt_idx];
                        r_src     <= w_gnt_idx;
                    end
                end
                S_SEND: begin
                    if (bus.bus_ready) begin
                        r_pending <= ~(CACHE_NUM'(1) << r_src);
                        r_timer   <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    r_pending <= w_pend_nxt;
                    r_timer   <= r_timer + 1'b1;
                    // A final ack in the timeout cycle counts as completion
                    if (w_all_acked) begin
                        r_msg_done <= CACHE_NUM'(1) << r_src;
                        r_rr_ptr   <= w_src_inc;
                    end else if (w_tmo) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_src_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.msg_gnt     = (r_state == S_IDLE && w_gnt_any && !rst)
                             ? (CACHE_NUM'(1) << w_gnt_idx) : '0;
    assign bus.bus_valid   = (r_state == S_SEND);
    assign bus.bus_msg     = r_bus_msg;
    assign bus.msg_done    = r_msg_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/coh_msg_sched.md
Name: coh_msg_sched

Overview:
- Schedules coherence messages from `CACHE_NUM` cache controllers onto a single shared broadcast message bus.
- Per transaction:
  - picks one requester round-robin and latches its message;
  - drives the message on the bus under a valid/ready handshake;
  - collects a snoop ack from every non-source cache;
  - signals completion to the source.
- Only one message is in flight at a time, which serialises coherence traffic between the caches' message ports and the snoop side of every cache.

Parameters:
- `CACHE_NUM`, 4: number of caches/requesters; must be >= 2.
- `ADDR_WIDTH`, 32: address field width.
- `ACK_TIMEOUT`, 255: maximum cycles spent in `WAIT_ACK` before abort; must be >= 1.
- Derived `ID_W` = `$clog2(CACHE_NUM)`.
- Derived `MSG_W` = 4 + 2*`ID_W` + `ADDR_WIDTH`.

Ports:
- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  synchronous active-high reset.
- `msg_req`  input  `CACHE_NUM`  per-cache message request.
- `msg`  input  `CACHE_NUM`*`MSG_W`  per-cache message; slot i at bits [i*`MSG_W` +: `MSG_W`].
- `msg_gnt`  output  `CACHE_NUM`  one-hot grant; message captured at the end of this cycle.
- `bus_valid`  output  1  broadcast message valid.
- `bus_msg`  output  `MSG_W`  broadcast message.
- `bus_ready`  input  1  bus accepts `bus_msg` when high with `bus_valid`.
- `snoop_ack`  input  `CACHE_NUM`  per-cache acknowledge of the current broadcast.
- `msg_done`  output  `CACHE_NUM`  one-hot, 1-cycle pulse to the source on completion.
- `timeout_err`  output  1  1-cycle pulse on ack timeout.
- `busy`  output  1  high when state != `IDLE`.

Behaviour:
Reset:
- `state`=`IDLE`, `rr_ptr`=0, `src`=0, `pending`=0, `timer`=0.
- `bus_valid`, `msg_done`, `timeout_err`, `busy` = 0; `bus_msg`=0; `msg_gnt`=0.

FSM `IDLE`:
- `msg_gnt` is combinational: the first set bit of `msg_req` scanning upward from `rr_ptr` with wrap.
- If any request is present, at the clock edge: latch `msg` slot into `bus_msg`, latch `src`, go to `SEND`.
- Latency: request seen in `IDLE` at cycle t -> `msg_gnt` at t -> `bus_valid` at t+1.
- A requester may hold `msg_req` for back-to-back messages.

FSM `SEND`:
- `bus_valid`=1; `bus_msg` is held stable until accepted.
- `msg_gnt`=0; `msg_req`/`msg` changes are ignored.
- On `bus_valid` & `bus_ready`: `pending` = all ones with bit `src` cleared, `timer`=0, go to `WAIT_ACK`.
- `snoop_ack` in `SEND` is ignored.

FSM `WAIT_ACK`:
- `bus_valid`=0.
- Each cycle: `pending` <= `pending` & ~`snoop_ack`; `timer` <= `timer`+1.
- `snoop_ack`[`src`] is ignored. Repeated acks from the same cache are harmless. Multiple acks may arrive in the same cycle.
- Completion: when (`pending` & ~`snoop_ack`)==0 -> next cycle `msg_done`[`src`]=1, `rr_ptr`=(`src`+1) mod `CACHE_NUM`, `state`=`IDLE`.
- Timeout: when `timer`==`ACK_TIMEOUT`-1 and acks are still outstanding -> next cycle `timeout_err`=1, `msg_done`=0, `rr_ptr` advances as on completion, `state`=`IDLE`.
- If the final ack lands in the timeout cycle, completion wins and `timeout_err` stays 0.

Back-to-back:
- In the `IDLE` cycle carrying the `msg_done`/`timeout_err` pulse, a new `msg_gnt` may be issued in the same cycle.

Wrap-around:
- `rr_ptr` wraps from `CACHE_NUM`-1 to 0.
- The request scan wraps modulo `CACHE_NUM`.

Output timing:
- `bus_msg` holds its last latched value outside `SEND`; it is meaningful only while `bus_valid` is high.
- `busy` is registered from `state`.

Reset mid-operation:
- Any state returns to `IDLE` on the next edge and the in-flight message is dropped.
- No `msg_done` or `timeout_err` is produced.
- `bus_valid` is low from the cycle after `rst`.

Test Plan:
1. `CACHE_NUM`=4, `IDLE`, `msg_req`=0010, `msg` slot1=0xA5..., `bus_ready`=1 -> `msg_gnt`=0010 same cycle; `bus_valid`=1 with slot1 value next cycle; `snoop_ack` 0001, 0100, 1000 on successive cycles -> `msg_done`=0010 one cycle after the 1000 ack.
2. `msg_req`=1111 held, `bus_ready`=1, all acks returned immediately -> grant order 0001, 0010, 0100, 1000, 0001; each `msg_done` matches its grant.
3. Grant slot2, `bus_ready`=0 for 5 cycles, with `msg`/`msg_req` toggling meanwhile -> `bus_valid`=1 and `bus_msg` constant for 5 cycles, `msg_gnt`=0; after `bus_ready`=1, `WAIT_ACK` is entered the next cycle.
4. Source 0 active; `snoop_ack`=0001 then 1110 in a single cycle -> the 0001 ack does not complete the transaction; `msg_done`=0001 after the 1110 cycle; a duplicate 0010 ack afterwards has no effect.
5. `ACK_TIMEOUT`=8, source 0, cache 3 never acks -> `timeout_err` pulses 8 cycles after `WAIT_ACK` entry, `msg_done`=0, next grant scan starts at 1. A variant where the final ack arrives on cycle 8 -> `msg_done`=0001, `timeout_err`=0.
6. `rst` asserted during `WAIT_ACK` (`rr_ptr`=2) -> next cycle all outputs 0; then `msg_req`=1001 -> `msg_gnt`=0001.
